// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// default widths, reset-sweep fill value and controller state encoding.
package dm_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam logic [15:0] INIT_VALUE_DEF = 16'h0000;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WR      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RSP     = 3'd4
  } state_e;

endpackage

// File: rtl/dm_access_ctrl_if.sv
// Request/response handshake plus DM port bundle of the MEM-stage controller.
// master = pipeline/memory side, slave = the controller.
interface dm_access_ctrl_if
  import dm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_busy;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_we;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, dm_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy,
           dm_addr, dm_wdata, dm_we
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, dm_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy,
           dm_addr, dm_wdata, dm_we
  );

endinterface

// File: rtl/dm_access_ctrl.sv
// Initiator side of the 16-bit data memory: clears every word after reset,
// then serves one load/store at a time with fully registered outputs.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = 16,
  parameter int READ_LAT = 0,
  parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(INIT_VALUE_DEF)
) (
  input logic             clk,
  input logic             rst,
  dm_access_ctrl_if.slave bus
);

  localparam int SW = $clog2(DEPTH + 1);
  localparam logic [SW-1:0] SWEEP_END = SW'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic LAT_LAST = (READ_LAT != 0);

  state_e            state_q, state_d;
  logic [SW-1:0]     sweep_q, sweep_d;
  logic              lat_q, lat_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              init_busy_q, init_busy_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic              dm_we_q, dm_we_d;
  logic              in_range_s;

  assign in_range_s = ({1'b0, bus.req_addr} < DEPTH_A);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      lat_q       <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      init_busy_q <= 1'b1;
      dm_addr_q   <= '0;
      dm_wdata_q  <= INIT_VALUE;
      dm_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      lat_q       <= lat_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      init_busy_q <= init_busy_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      dm_we_q     <= dm_we_d;
    end
  end

  // Next state; pulse-type outputs default low, everything else holds.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    lat_d       = lat_q;
    err_d       = err_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    init_busy_d = init_busy_q;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    dm_we_d     = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (sweep_q < SWEEP_END) begin
          dm_addr_d  = ADDR_W'(sweep_q);
          dm_wdata_d = INIT_VALUE;
          dm_we_d    = 1'b1;
          sweep_d    = sweep_q + SW'(1);
        end else begin
          init_busy_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          dm_addr_d   = bus.req_addr;
          if (bus.req_write) begin
            dm_wdata_d = bus.req_wdata;
            // Out-of-range stores still burn the WR cycle, just without a write.
            dm_we_d    = in_range_s;
            state_d    = ST_WR;
          end else begin
            err_d   = ~in_range_s;
            lat_d   = 1'b0;
            state_d = ST_RD_WAIT;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_WR: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          rsp_rdata_d = err_q ? '0 : bus.dm_rdata;
          state_d     = ST_RSP;
        end else begin
          lat_d = 1'b1;
        end
      end
      ST_RSP: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        sweep_d     = '0;
        req_ready_d = 1'b0;
        init_busy_d = 1'b1;
        state_d     = ST_INIT;
      end
    endcase
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.init_busy = init_busy_q;
  assign bus.dm_addr   = dm_addr_q;
  assign bus.dm_wdata  = dm_wdata_q;
  assign bus.dm_we     = dm_we_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: one instance with READ_LAT=0 and one
// with READ_LAT=1, each attached to a small behavioural 16-word DM.
module tb_dm_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dm_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) if0 ();
  dm_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) if1 ();

  dm_access_ctrl #(.READ_LAT(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  dm_access_ctrl #(.READ_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  logic [15:0] rd1_q;

  always @(posedge clk) begin
    if (if0.dm_we && (if0.dm_addr < 16'd16)) mem0[if0.dm_addr[3:0]] <= if0.dm_wdata;
    if (if1.dm_we && (if1.dm_addr < 16'd16)) mem1[if1.dm_addr[3:0]] <= if1.dm_wdata;
    rd1_q <= mem1[if1.dm_addr[3:0]];
  end

  assign if0.dm_rdata = (if0.dm_addr < 16'd16) ? mem0[if0.dm_addr[3:0]] : 16'hDEAD;
  assign if1.dm_rdata = rd1_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
    if0.req_valid = v;
    if0.req_write = w;
    if0.req_addr  = a;
    if0.req_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
    if1.req_valid = v;
    if1.req_write = w;
    if1.req_addr  = a;
    if1.req_wdata = d;
  endtask

  task automatic store0(input logic [15:0] a, input logic [15:0] d);
    drive0(1'b1, 1'b1, a, d);
    tick();
    drive0(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("st_we", {31'd0, if0.dm_we}, {31'd0, (a < 16'd16)});
    check("st_addr", {16'd0, if0.dm_addr}, {16'd0, a});
    check("st_wdata", {16'd0, if0.dm_wdata}, {16'd0, d});
    check("st_ready_lo", {31'd0, if0.req_ready}, 32'd0);
    tick();
    check("st_we_off", {31'd0, if0.dm_we}, 32'd0);
    check("st_ready_hi", {31'd0, if0.req_ready}, 32'd1);
  endtask

  task automatic load0(input logic [15:0] a, input logic [15:0] exp_d, input logic exp_e);
    drive0(1'b1, 1'b0, a, 16'h0000);
    tick();
    drive0(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("ld_addr", {16'd0, if0.dm_addr}, {16'd0, a});
    check("ld_we", {31'd0, if0.dm_we}, 32'd0);
    check("ld_early_rsp", {31'd0, if0.rsp_valid}, 32'd0);
    tick();
    check("ld_rsp_valid", {31'd0, if0.rsp_valid}, 32'd1);
    check("ld_rdata", {16'd0, if0.rsp_rdata}, {16'd0, exp_d});
    check("ld_err", {31'd0, if0.rsp_err}, {31'd0, exp_e});
    tick();
    check("ld_rsp_end", {31'd0, if0.rsp_valid}, 32'd0);
    check("ld_ready_hi", {31'd0, if0.req_ready}, 32'd1);
    check("ld_rdata_hold", {16'd0, if0.rsp_rdata}, {16'd0, exp_d});
  endtask

  initial begin
    drive0(1'b0, 1'b0, 16'h0000, 16'h0000);
    drive1(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    check("rst_ready", {31'd0, if0.req_ready}, 32'd0);
    check("rst_busy", {31'd0, if0.init_busy}, 32'd1);
    check("rst_we", {31'd0, if0.dm_we}, 32'd0);
    check("rst_addr", {16'd0, if0.dm_addr}, 32'd0);
    check("rst_wdata", {16'd0, if0.dm_wdata}, 32'd0);
    check("rst_rsp", {29'd0, if0.rsp_valid, if0.rsp_err, 1'b0}, 32'd0);
    check("rst_rdata", {16'd0, if0.rsp_rdata}, 32'd0);
    rst = 1'b0;

    // Sweep; a store request held during the first half must be ignored.
    for (int i = 0; i < 16; i++) begin
      drive0(i < 8, 1'b1, 16'h0005, 16'hBEEF);
      tick();
      check("sw_we", {31'd0, if0.dm_we}, 32'd1);
      check("sw_addr", {16'd0, if0.dm_addr}, i);
      check("sw_wdata", {16'd0, if0.dm_wdata}, 32'd0);
      check("sw_busy", {31'd0, if0.init_busy}, 32'd1);
      check("sw_ready", {31'd0, if0.req_ready}, 32'd0);
      check("sw1_addr", {16'd0, if1.dm_addr}, i);
    end
    drive0(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    check("sw_done_we", {31'd0, if0.dm_we}, 32'd0);
    check("sw_done_busy", {31'd0, if0.init_busy}, 32'd0);
    check("sw_done_ready", {31'd0, if0.req_ready}, 32'd1);
    check("sw1_done_ready", {31'd0, if1.req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) load0(16'(i), 16'h0000, 1'b0);

    store0(16'h0000, 16'hFFFF);
    load0(16'h0000, 16'hFFFF, 1'b0);

    for (int i = 0; i < 16; i++) store0(16'(i), 16'(i * 16'h1111));
    for (int i = 0; i < 16; i++) load0(16'(i), 16'(i * 16'h1111), 1'b0);

    load0(16'h0010, 16'h0000, 1'b1);
    store0(16'h0014, 16'h1234);
    load0(16'h0004, 16'h4444, 1'b0);

    // Store then load to the same address with req_valid held throughout.
    drive0(1'b1, 1'b1, 16'h0007, 16'hA5C3);
    tick();
    drive0(1'b1, 1'b0, 16'h0007, 16'h0000);
    check("b2b_wr_we", {31'd0, if0.dm_we}, 32'd1);
    check("b2b_wr_data", {16'd0, if0.dm_wdata}, 32'h0000A5C3);
    tick();
    check("b2b_idle_ready", {31'd0, if0.req_ready}, 32'd1);
    tick();
    drive0(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("b2b_rd_addr", {16'd0, if0.dm_addr}, 32'd7);
    check("b2b_rd_we", {31'd0, if0.dm_we}, 32'd0);
    tick();
    check("b2b_rsp", {31'd0, if0.rsp_valid}, 32'd1);
    check("b2b_rdata", {16'd0, if0.rsp_rdata}, 32'h0000A5C3);
    tick();

    // READ_LAT=1 instance: store, then a load with req_valid held twice over.
    drive1(1'b1, 1'b1, 16'h0009, 16'h1357);
    tick();
    drive1(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("l1_st_we", {31'd0, if1.dm_we}, 32'd1);
    tick();
    drive1(1'b1, 1'b0, 16'h0009, 16'h0000);
    tick();
    check("l1_rd1_addr", {16'd0, if1.dm_addr}, 32'd9);
    check("l1_rd1_ready", {31'd0, if1.req_ready}, 32'd0);
    tick();
    check("l1_rd2_addr", {16'd0, if1.dm_addr}, 32'd9);
    check("l1_rd2_rsp", {31'd0, if1.rsp_valid}, 32'd0);
    check("l1_rd2_ready", {31'd0, if1.req_ready}, 32'd0);
    tick();
    check("l1_rsp", {31'd0, if1.rsp_valid}, 32'd1);
    check("l1_rdata", {16'd0, if1.rsp_rdata}, 32'h00001357);
    check("l1_rsp_ready", {31'd0, if1.req_ready}, 32'd0);
    tick();
    check("l1_idle_ready", {31'd0, if1.req_ready}, 32'd1);
    check("l1_idle_rsp", {31'd0, if1.rsp_valid}, 32'd0);
    tick();
    drive1(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("l1_reacc_ready", {31'd0, if1.req_ready}, 32'd0);
    check("l1_reacc_addr", {16'd0, if1.dm_addr}, 32'd9);
    tick();
    tick();
    check("l1_rsp2", {31'd0, if1.rsp_valid}, 32'd1);
    check("l1_rdata2", {16'd0, if1.rsp_rdata}, 32'h00001357);
    tick();

    // Asynchronous reset while a load sits in RD_WAIT.
    drive0(1'b1, 1'b0, 16'h0003, 16'h0000);
    tick();
    drive0(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("mr_rd_addr", {16'd0, if0.dm_addr}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("mr_async_busy", {31'd0, if0.init_busy}, 32'd1);
    check("mr_async_addr", {16'd0, if0.dm_addr}, 32'd0);
    check("mr_async_ready", {31'd0, if0.req_ready}, 32'd0);
    check("mr_async_rsp", {31'd0, if0.rsp_valid}, 32'd0);
    tick();
    check("mr_no_rsp", {31'd0, if0.rsp_valid}, 32'd0);
    rst = 1'b0;
    tick();
    check("mr_sweep_we", {31'd0, if0.dm_we}, 32'd1);
    check("mr_sweep_addr", {16'd0, if0.dm_addr}, 32'd0);
    check("mr_sweep_rsp", {31'd0, if0.rsp_valid}, 32'd0);
    tick();
    check("mr_sweep_addr1", {16'd0, if0.dm_addr}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator side of the 16-bit data-memory interface (the DM block: addr_in, data_in, data_out, WriteEnable).
- Sits in the MEM stage of the pipelined MIPS core.
- Accepts load/store requests from EX/MEM over a valid/ready handshake, drives the DM port, and returns load data with a one-cycle response pulse.
- After every reset, sweeps the whole DM and writes INIT_VALUE to each word before accepting any request.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 16, address width on request and DM ports.
- DEPTH, 16, number of implemented DM words; valid addresses are 0..DEPTH-1.
- READ_LAT, 0, DM read latency in cycles after the address is presented (0 or 1).
- INIT_VALUE, 16'h0000, word written to every location during the reset sweep.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle pulse: load data valid.
- rsp_rdata  out  DATA_W  load data.
- rsp_err  out  1  qualifies rsp_valid: address was out of range.
- init_busy  out  1  reset sweep in progress.
- dm_addr  out  ADDR_W  to DM addr_in.
- dm_wdata  out  DATA_W  to DM data_in.
- dm_we  out  1  to DM WriteEnable.
- dm_rdata  in  DATA_W  from DM data_out.

Behaviour:
- Outputs:
  - All outputs are registered.
  - Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1, dm_addr=0, dm_wdata=INIT_VALUE, dm_we=0.
- States: INIT, IDLE, WR, RD_WAIT, RSP.
- INIT:
  - Entered on reset.
  - The first cycle after rst deasserts drives dm_addr=0, dm_wdata=INIT_VALUE, dm_we=1.
  - dm_addr increments by 1 each cycle through DEPTH-1, so the sweep lasts exactly DEPTH cycles with dm_we=1.
  - Next cycle: dm_we=0, init_busy=0, req_ready=1, state=IDLE.
  - Requests are ignored throughout INIT.
- IDLE:
  - req_ready=1.
  - A request is accepted in a cycle N where req_valid&req_ready; req_ready drops to 0 in cycle N+1.
- Store accepted in cycle N:
  - State WR in cycle N+1: dm_addr=req_addr, dm_wdata=req_wdata, dm_we=1 for exactly one cycle.
  - Back to IDLE in cycle N+2 with req_ready=1.
  - Maximum rate is one store per 2 cycles.
- Load accepted in cycle N:
  - dm_addr=req_addr from cycle N+1, dm_we=0.
  - dm_rdata is sampled at the end of cycle N+1+READ_LAT (state RD_WAIT holds dm_addr stable for 1+READ_LAT cycles).
  - rsp_valid=1 for exactly cycle N+2+READ_LAT (state RSP).
  - IDLE follows, so req_ready=1 in cycle N+3+READ_LAT.
  - rsp_rdata holds its last value until the next load response.
- Out-of-range address (req_addr >= DEPTH):
  - Store: dm_we stays 0; the WR cycle is still spent.
  - Load: no DM sample; rsp_valid pulses with rsp_rdata=0 and rsp_err=1 at the normal latency.
  - rsp_err is 0 on all in-range responses.
- Request fields are captured at acceptance; later changes on req_* have no effect.
- dm_we is never 1 in IDLE, RD_WAIT or RSP.
- Back-to-back requests:
  - A request held valid during WR/RD_WAIT/RSP is accepted in the first IDLE cycle.
  - A load immediately after a store to the same address returns the new data, because the store completes before the load address is presented.
- Reset mid-operation:
  - Asynchronous return to reset values and INIT.
  - An in-flight store may not complete.
  - An in-flight load produces no rsp_valid.
  - The sweep restarts from address 0.

Decomposition:
- Shared package dm_pkg holds:
  - DATA_W and ADDR_W defaults.
  - State encoding constants ST_INIT, ST_IDLE, ST_WR, ST_RD_WAIT, ST_RSP.
  - INIT_VALUE default.
- No sub-module: the sweep counter and the read-latency counter live inline.

Test Plan:
- Reset then release: init_busy=1 and dm_we=1 for exactly 16 cycles, with dm_addr 0..15 ascending and dm_wdata=0; then req_ready=1 and init_busy=0.
- Store addr=0 data=16'hFFFF, then load addr=0: dm_we pulses one cycle with addr 0; rsp_valid pulses 2 cycles after load acceptance (READ_LAT=0) with rsp_rdata=16'hFFFF and rsp_err=0.
- Loads to addr 0..15 after the sweep: each returns 16'h0000; later stores of i*16'h1111 read back exactly.
- Load addr=16 (DEPTH=16): rsp_valid with rsp_rdata=0 and rsp_err=1. Store addr=20: dm_we never asserts.
- READ_LAT=1 build: load-to-rsp_valid is 3 cycles; dm_addr is held for 2 cycles; a continuously held req_valid is re-accepted only in IDLE.
- Assert rst during RD_WAIT: no rsp_valid; the outputs go to reset values immediately without waiting for a clock edge; the sweep restarts at dm_addr=0.
